cpu_core_seq: RTL and testbench

//  Parametrised successor of the single-bus CPU datapath: an NREG x DATA_W register file,
//  an add/sub unit with operand and result registers, and a built-in sequencer that fetches
//  32-bit instructions from ROM and executes them. Stores go out on a VALID/READY write bus.

---
 rtl/cpu_core_seq_pkg.sv | 50 +++++
 rtl/core_regfile.sv | 55 +++++
 rtl/cpu_core_seq.sv | 182 ++++++++++++++++++
 tb/tb_cpu_core_seq.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_core_seq_pkg
// Purpose : Shared definitions for the cpu_core_seq sequencer core. It holds
//           the FSM state type, the opcode values, the instruction field bit
//           positions and a small decode helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package cpu_core_seq_pkg;

  // Register index width fixed by the 4-bit instruction fields
  localparam int REG_IDX_W = 4;

  // Instruction field bit positions
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 24;
  localparam int RS_MSB  = 23;
  localparam int RS_LSB  = 20;
  localparam int IMM_MSB = 15;

  // Opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_BNZ  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_STORE = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  // Opcodes 8..E are reserved; they execute as NOP and raise the error flag
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'h8) && (op <= 4'hE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_regfile.sv
`default_nettype none
// ============================================================================
// Module  : core_regfile
// Purpose : NREG x DATA_W general purpose register file, one write port and
//           two combinational read ports. Indices >= NREG read as zero and
//           writes to them are dropped.
// Ports   : clk, rst_n          clock / async active-low reset (clears all)
//           we, waddr, wdata    write port
//           raddr_a / rdata_a   read port A
//           raddr_b / rdata_b   read port B
// Rev     : 1.0  initial release
// ============================================================================
module core_regfile
  import cpu_core_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr_a,
  output logic [DATA_W-1:0]    rdata_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic [DATA_W-1:0]    rdata_b
);

  logic [DATA_W-1:0] regs [NREG];

  // Each entry decodes its own index, so an out-of-range waddr matches no
  // entry and the write disappears without any explicit range check.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[i] <= '0;
      end else if (we && (waddr == REG_IDX_W'(i))) begin
        regs[i] <= wdata;
      end
    end
  end

  // Same idea on the read side: no match leaves the zero default.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (raddr_a == REG_IDX_W'(i)) rdata_a = regs[i];
      if (raddr_b == REG_IDX_W'(i)) rdata_b = regs[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_core_seq.sv
`default_nettype none
// ============================================================================
// Module  : cpu_core_seq
// Purpose : Sequenced single-bus CPU core. It fetches 32-bit instructions from
//           a combinational ROM, executes them on a register file and an
//           add/sub unit, and issues stores on a VALID/READY write bus.
// Ports   : clk, rst_n      clock / async active-low reset
//           RUN             execute enable (sampled in IDLE, FETCH, HALT)
//           ROM_IN/ROM_ADDR instruction word / program counter
//           ADDR_BUS, DATA_WBUS, BUS_VALID, SLAVE_READY   store bus
//           HALTED          high while in HALT
//           ERR             sticky illegal-opcode flag
// Rev     : 1.0  initial release
// ============================================================================
module cpu_core_seq
  import cpu_core_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int ADDR_W = 32,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RUN,
  input  logic [31:0]       ROM_IN,
  output logic [PC_W-1:0]   ROM_ADDR,
  output logic [ADDR_W-1:0] ADDR_BUS,
  output logic [DATA_W-1:0] DATA_WBUS,
  output logic              BUS_VALID,
  input  logic              SLAVE_READY,
  output logic              HALTED,
  output logic              ERR
);

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc;
  logic [31:0]         ir;
  logic [DATA_W-1:0]   opnd_q, result_q, data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                valid_q, err_q;

  logic [3:0]            op;
  logic [REG_IDX_W-1:0]  rd_idx, rs_idx;
  logic [IMM_MSB:0]      imm;
  logic [DATA_W-1:0]     rd_val, rs_val, alu_out;
  logic                  rf_we;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  xfer;

  assign op     = ir[OP_MSB:OP_LSB];
  assign rd_idx = ir[RD_MSB:RD_LSB];
  assign rs_idx = ir[RS_MSB:RS_LSB];
  assign imm    = ir[IMM_MSB:0];
  assign xfer   = valid_q & SLAVE_READY;

  assign alu_out = (op == OP_SUB) ? (rd_val - rs_val) : (rd_val + rs_val);

  // ir[19:16] is a reserved field and opnd_q only records the first ADD/SUB
  // operand; neither feeds any datapath logic.
  logic unused_bits;
  assign unused_bits = ^{ir[19:16], opnd_q};

  core_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rd_idx),
    .wdata   (rf_wdata),
    .raddr_a (rd_idx),
    .rdata_a (rd_val),
    .raddr_b (rs_idx),
    .rdata_b (rs_val)
  );

  // Register-file write: LDI/MOV write in EXEC, ADD/SUB write back in WB.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = result_q;
    case (state)
      ST_EXEC: begin
        case (op)
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(imm);
          end
          OP_MOV: begin
            rf_we    = 1'b1;
            rf_wdata = rs_val;
          end
          default: ;
        endcase
      end
      ST_WB:   rf_we = 1'b1;
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; RUN is only looked at outside EXEC/WB/STORE so an
  // instruction (and any store) always runs to completion.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (RUN) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = RUN ? ST_EXEC : ST_IDLE;
      ST_EXEC: begin
        case (op)
          OP_ADD, OP_SUB: state_nxt = ST_WB;
          OP_ST:          state_nxt = ST_STORE;
          OP_HALT:        state_nxt = ST_HALT;
          default:        state_nxt = ST_FETCH;
        endcase
      end
      ST_WB:    state_nxt = ST_FETCH;
      ST_STORE: if (xfer) state_nxt = ST_FETCH;
      ST_HALT:  if (!RUN) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: pc, IR, ALU registers, bus registers, error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      ir       <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (RUN) begin
            ir <= ROM_IN;
            pc <= pc + PC_W'(1);
          end
        end
        ST_EXEC: begin
          if (is_illegal(op)) err_q <= 1'b1;
          case (op)
            OP_ADD, OP_SUB: begin
              opnd_q   <= rd_val;
              result_q <= alu_out;
            end
            OP_ST: begin
              addr_q  <= rs_val[ADDR_W-1:0];
              data_q  <= rd_val;
              valid_q <= 1'b1;
            end
            // Branch targets replace the increment already applied in FETCH
            OP_JMP: pc <= imm[PC_W-1:0];
            OP_BNZ: if (rd_val != '0) pc <= imm[PC_W-1:0];
            default: ;
          endcase
        end
        ST_STORE: if (xfer) valid_q <= 1'b0;
        ST_HALT:  if (!RUN) pc <= '0;
        default: ;
      endcase
    end
  end

  assign ROM_ADDR  = pc;
  assign ADDR_BUS  = addr_q;
  assign DATA_WBUS = data_q;
  assign BUS_VALID = valid_q;
  assign HALTED    = (state == ST_HALT);
  assign ERR       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_core_seq
// Purpose : Self-checking bench for cpu_core_seq. A default-parameter core
//           (a) and a NREG=4 / PC_W=2 core (b) run directed and random
//           programs; an instruction-level model predicts stores, cycles
//           and the error flag.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_core_seq;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // core a : default parameters
  logic        run_a, ready_a, valid_a, halted_a, err_a;
  logic [31:0] rom_in_a, addr_a, data_a;
  logic [7:0]  rom_addr_a;
  logic [31:0] rom_a [256];
  assign rom_in_a = rom_a[rom_addr_a];

  // core b : NREG=4, PC_W=2
  logic        run_b, ready_b, valid_b, halted_b, err_b;
  logic [31:0] rom_in_b, addr_b, data_b;
  logic [1:0]  rom_addr_b;
  logic [31:0] rom_b [4];
  assign rom_in_b = rom_b[rom_addr_b];

  cpu_core_seq dut_a (
    .clk(clk), .rst_n(rst_n), .RUN(run_a), .ROM_IN(rom_in_a), .ROM_ADDR(rom_addr_a),
    .ADDR_BUS(addr_a), .DATA_WBUS(data_a), .BUS_VALID(valid_a), .SLAVE_READY(ready_a),
    .HALTED(halted_a), .ERR(err_a)
  );

  cpu_core_seq #(.DATA_W(32), .NREG(4), .ADDR_W(32), .PC_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .RUN(run_b), .ROM_IN(rom_in_b), .ROM_ADDR(rom_addr_b),
    .ADDR_BUS(addr_b), .DATA_WBUS(data_b), .BUS_VALID(valid_b), .SLAVE_READY(ready_b),
    .HALTED(halted_b), .ERR(err_b)
  );

  int total = 0;
  int bad   = 0;

  xfer_t obs_a[$];
  xfer_t obs_b[$];
  always @(negedge clk) begin
    if (rst_n && valid_a && ready_a) obs_a.push_back({addr_a, data_a});
    if (rst_n && valid_b && ready_b) obs_b.push_back({addr_b, data_b});
  end

  // READY for core a: forced level or random per cycle
  int   rdy_mode  = 0;
  logic rdy_force = 1'b1;
  initial begin
    ready_a = 1'b1;
    ready_b = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ready_a = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // ---------------- instruction-level reference model ----------------
  logic [31:0] mrom [256];
  xfer_t       m_stores[$];
  logic        m_err, m_halted;
  int          m_cycles;

  task automatic model_run(input int nreg, input int pcw);
    logic [31:0] r [16];
    logic [31:0] ins, rdv, rsv, imm;
    int pc, op, rd, rs;
    foreach (r[k]) r[k] = 32'h0;
    pc = 0; m_stores.delete(); m_err = 1'b0; m_halted = 1'b0; m_cycles = 0;
    for (int step = 0; step < 5000 && !m_halted; step++) begin
      ins = mrom[pc];
      pc  = (pc + 1) % (1 << pcw);
      op  = int'(ins[31:28]);
      rd  = int'(ins[27:24]);
      rs  = int'(ins[23:20]);
      imm = {16'h0, ins[15:0]};
      rdv = (rd < nreg) ? r[rd] : 32'h0;
      rsv = (rs < nreg) ? r[rs] : 32'h0;
      m_cycles += 2;
      case (op)
        0:  ;
        1:  if (rd < nreg) r[rd] = imm;
        2:  if (rd < nreg) r[rd] = rsv;
        3:  begin if (rd < nreg) r[rd] = rdv + rsv; m_cycles += 1; end
        4:  begin if (rd < nreg) r[rd] = rdv - rsv; m_cycles += 1; end
        5:  begin m_stores.push_back({rsv, rdv}); m_cycles += 1; end
        6:  pc = int'(imm) % (1 << pcw);
        7:  if (rdv != 0) pc = int'(imm) % (1 << pcw);
        15: m_halted = 1'b1;
        default: m_err = 1'b1;
      endcase
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    run_a = 1'b0; run_b = 1'b0; rdy_mode = 0; rdy_force = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    obs_a.delete(); obs_b.delete();
  endtask

  task automatic load_a(input logic [31:0] prog [$]);
    foreach (rom_a[k]) rom_a[k] = 32'hF000_0000;
    foreach (prog[k]) rom_a[k] = prog[k];
    foreach (rom_a[k]) mrom[k] = rom_a[k];
  endtask

  task automatic load_b(input logic [31:0] prog [$]);
    foreach (rom_b[k]) rom_b[k] = prog[k];
    foreach (rom_b[k]) mrom[k] = rom_b[k];
  endtask

  // Raise RUN, let IDLE->FETCH happen, then count edges until HALTED
  task automatic go(input bit use_b, input int budget, output int cyc, output bit done);
    if (use_b) run_b = 1'b1; else run_a = 1'b1;
    @(posedge clk); #1;
    done = 1'b0; cyc = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if ((use_b ? halted_b : halted_a) === 1'b1) done = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (rom_addr_a !== 8'h0) begin bad++; $display("FAIL reset_pc_a: got %h want 00", rom_addr_a); end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
    total++; if (halted_a !== 1'b0) begin bad++; $display("FAIL reset_halted_a: got %b want 0", halted_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL reset_err_a: got %b want 0", err_a); end
    total++; if ({addr_a, data_a} !== 64'h0) begin bad++; $display("FAIL reset_bus_a: got %h want 0", {addr_a, data_a}); end
    total++; if ({rom_addr_b, valid_b, halted_b, err_b} !== 5'h0) begin bad++; $display("FAIL reset_b: got %h want 00", {rom_addr_b, valid_b, halted_b, err_b}); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (rom_addr_a !== 8'h0) begin bad++; $display("FAIL idle_hold_pc: got %h want 00", rom_addr_a); end
  endtask

  task automatic test_add();
    int cyc; bit done;
    do_reset();
    load_a('{32'h1100_0005, 32'h1200_0003, 32'h3120_0000, 32'hF000_0000});
    go(1'b0, 50, cyc, done);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL add_halt: timeout, got %b want 1", done); end
    total++; if (cyc != 9) begin bad++; $display("FAIL add_cycles: got %0d want 9", cyc); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL add_err: got %b want 0", err_a); end
    // Same program with a store exposing r1
    do_reset();
    load_a('{32'h1100_0005, 32'h1200_0003, 32'h3120_0000, 32'h5100_0000, 32'hF000_0000});
    model_run(16, 8);
    go(1'b0, 50, cyc, done);
    total++; if (cyc != m_cycles) begin bad++; $display("FAIL add_st_cycles: got %0d want %0d", cyc, m_cycles); end
    total++; if (obs_a.size() != 1 || obs_a[0] !== {32'h0, 32'd8}) begin bad++; $display("FAIL add_result: got %0d xfers, first %h want 0000000000000008", obs_a.size(), (obs_a.size() > 0) ? obs_a[0] : 64'h0); end
  endtask

  task automatic test_sub_wrap();
    int cyc; bit done;
    do_reset();
    load_a('{32'h1100_0000, 32'h1200_0001, 32'h4120_0000, 32'h5100_0000, 32'hF000_0000});
    go(1'b0, 50, cyc, done);
    total++; if (done !== 1'b1 || obs_a.size() != 1 || obs_a[0] !== {32'h0, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL sub_wrap: halted=%b xfers=%0d first=%h want 00000000ffffffff", done, obs_a.size(), (obs_a.size() > 0) ? obs_a[0] : 64'h0);
    end
  endtask

  task automatic test_store();
    int cyc; bit done; bit seen;
    do_reset();
    rdy_force = 1'b0;
    load_a('{32'h1300_1234, 32'h1400_0040, 32'h5340_0000, 32'hF000_0000});
    run_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (valid_a === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL store_valid_rise: got 0 want 1 within 20 cycles"); end
    for (int c = 0; c < 4; c++) begin
      total++; if ({valid_a, addr_a, data_a} !== {1'b1, 32'h40, 32'h1234}) begin
        bad++; $display("FAIL store_hold_c%0d: got v=%b a=%h d=%h want v=1 a=00000040 d=00001234", c, valid_a, addr_a, data_a);
      end
      if (c == 3) rdy_force = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (valid_a !== 1'b0 || rom_addr_a !== 8'd3) begin bad++; $display("FAIL store_done: got v=%b pc=%0d want v=0 pc=3", valid_a, rom_addr_a); end
    go(1'b0, 20, cyc, done);
    total++; if (done !== 1'b1 || obs_a.size() != 1) begin bad++; $display("FAIL store_count: got %0d xfers halted=%b want 1 halted=1", obs_a.size(), done); end
  endtask

  task automatic test_loop();
    int cyc; bit done;
    do_reset();
    load_a('{32'h1100_0003, 32'h1200_0001, 32'h4120_0000, 32'h7100_0002, 32'h5100_0000, 32'hF000_0000});
    model_run(16, 8);
    go(1'b0, 100, cyc, done);
    total++; if (done !== 1'b1 || cyc != 24) begin bad++; $display("FAIL loop_cycles: got %0d halted=%b want 24", cyc, done); end
    total++; if (cyc != m_cycles) begin bad++; $display("FAIL loop_model_cycles: got %0d want %0d", cyc, m_cycles); end
    total++; if (obs_a.size() != 1 || obs_a[0] !== 64'h0) begin bad++; $display("FAIL loop_r1: got %0d xfers first=%h want one xfer 0", obs_a.size(), (obs_a.size() > 0) ? obs_a[0] : 64'h0); end
  endtask

  task automatic test_pause_illegal();
    logic [7:0] held;
    bit done;
    do_reset();
    load_a('{32'h1100_0007, 32'h9000_0000, 32'h3110_0000, 32'h5100_0000,
             32'h1200_0002, 32'h5210_0000, 32'hF000_0000});
    model_run(16, 8);
    run_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++; if (err_a !== 1'b1) begin bad++; $display("FAIL illegal_err: got %b want 1", err_a); end
    run_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 held = rom_addr_a;
    repeat (5) @(posedge clk);
    #1;
    total++; if (rom_addr_a !== held || held !== 8'd3) begin bad++; $display("FAIL pause_pc: got %0d then %0d want 3", held, rom_addr_a); end
    total++; if (obs_a.size() != 0) begin bad++; $display("FAIL pause_nostore: got %0d xfers want 0", obs_a.size()); end
    run_a = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (halted_a === 1'b1) done = 1'b1;
    end
    total++; if (done !== 1'b1 || obs_a.size() != m_stores.size()) begin bad++; $display("FAIL resume_xfers: got %0d halted=%b want %0d", obs_a.size(), done, m_stores.size()); end
    else foreach (m_stores[k]) begin
      total++; if (obs_a[k] !== m_stores[k]) begin bad++; $display("FAIL resume_xfer%0d: got %h want %h", k, obs_a[k], m_stores[k]); end
    end
    run_a = 1'b0;
    @(posedge clk); #1;
    total++; if ({halted_a, rom_addr_a, err_a} !== {1'b0, 8'h0, 1'b1}) begin bad++; $display("FAIL halt_exit: got h=%b pc=%h err=%b want h=0 pc=00 err=1", halted_a, rom_addr_a, err_a); end
    // Reset in the middle of a stalled store
    do_reset();
    rdy_force = 1'b0;
    load_a('{32'h1300_0055, 32'h5300_0000, 32'hF000_0000});
    run_a = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (valid_a === 1'b1) done = 1'b1;
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rst_store_start: got 0 want valid within 20 cycles"); end
    rst_n = 1'b0;
    #1;
    total++; if ({valid_a, rom_addr_a, err_a} !== 10'h0) begin bad++; $display("FAIL rst_mid_store: got v=%b pc=%h err=%b want all 0", valid_a, rom_addr_a, err_a); end
    total++; if (obs_a.size() != 0) begin bad++; $display("FAIL rst_no_xfer: got %0d want 0", obs_a.size()); end
    do_reset();
  endtask

  task automatic test_small_params();
    int cyc; bit done;
    do_reset();
    load_b('{32'h1700_0009, 32'h2170_0000, 32'h5100_0000, 32'hF000_0000});
    go(1'b1, 40, cyc, done);
    total++; if (done !== 1'b1 || obs_b.size() != 1 || obs_b[0] !== 64'h0) begin
      bad++; $display("FAIL small_discard: halted=%b xfers=%0d first=%h want one xfer 0", done, obs_b.size(), (obs_b.size() > 0) ? obs_b[0] : 64'h0);
    end
    do_reset();
    load_b('{32'h7200_0002, 32'h6000_0003, 32'hF000_0000, 32'h1200_0001});
    model_run(4, 2);
    go(1'b1, 40, cyc, done);
    total++; if (done !== 1'b1 || cyc != 10) begin bad++; $display("FAIL small_wrap: got %0d cycles halted=%b want 10", cyc, done); end
    total++; if (cyc != m_cycles || m_halted !== 1'b1) begin bad++; $display("FAIL small_wrap_model: got %0d want %0d", cyc, m_cycles); end
  endtask

  task automatic test_random();
    logic [31:0] prog [$];
    logic [3:0]  op, rd, rs;
    logic [15:0] imm;
    int cyc; bit done;
    for (int it = 0; it < 6; it++) begin
      prog.delete();
      for (int i = 0; i < 20; i++) begin
        rd  = 4'($urandom_range(0, 15));
        rs  = 4'($urandom_range(0, 15));
        imm = 16'($urandom_range(0, 65535));
        case ($urandom_range(0, 9))
          0, 1: op = 4'h1;
          2:    op = 4'h2;
          3:    op = 4'h3;
          4:    op = 4'h4;
          5:    op = 4'h5;
          6:    op = 4'h0;
          7:    begin op = 4'h7; imm = 16'($urandom_range(i + 1, 20)); end
          8:    op = 4'($urandom_range(8, 14));
          default: begin op = 4'h6; imm = 16'($urandom_range(i + 1, 20)); end
        endcase
        prog.push_back({op, rd, rs, 4'h0, imm});
      end
      for (int k = 0; k < 16; k++) prog.push_back({4'h5, 4'(k), 4'(k), 20'h0});
      prog.push_back(32'hF000_0000);
      do_reset();
      load_a(prog);
      model_run(16, 8);
      rdy_mode = 1;
      go(1'b0, 3000, cyc, done);
      total++; if (done !== 1'b1 || obs_a.size() != m_stores.size()) begin
        bad++; $display("FAIL rand%0d_count: got %0d xfers halted=%b want %0d", it, obs_a.size(), done, m_stores.size());
      end else foreach (m_stores[k]) begin
        total++; if (obs_a[k] !== m_stores[k]) begin bad++; $display("FAIL rand%0d_xfer%0d: got %h want %h", it, k, obs_a[k], m_stores[k]); end
      end
      total++; if (err_a !== m_err) begin bad++; $display("FAIL rand%0d_err: got %b want %b", it, err_a, m_err); end
    end
  endtask

  initial begin
    foreach (rom_a[k]) rom_a[k] = 32'hF000_0000;
    foreach (rom_b[k]) rom_b[k] = 32'hF000_0000;
    test_reset();
    test_add();
    test_sub_wrap();
    test_store();
    test_loop();
    test_pause_illegal();
    test_small_params();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
